mux_2to1: RTL and testbench
===========================

Name: mux_2to1

Overview:
- Generic 2-input word multiplexer used across the MIPS datapath: ALU operand select, writeback select, PC source.
- A single flag chooses which of two equal-width inputs drives the output.
- The output path is combinational by default. A parameter adds one optional output register stage for timing-critical datapath points.
- Clock and reset are always present on the port list so both variants share one interface.

Parameters:
- WIDTH, 32, bit width of both data inputs and the output.
- OUTPUT_REG, 0, 0 = combinational output; 1 = output registered on clk (latency 1).
- RESET_VALUE, 0, value loaded into the output register on reset (used only when OUTPUT_REG=1); WIDTH bits.

Ports:
- clk  input  1  system clock; rising edge active; unused when OUTPUT_REG=0.
- rst  input  1  reset, synchronous, active-high; unused when OUTPUT_REG=0.
- genericValue1  input  WIDTH  data input selected when genericF=1.
- genericValue2  input  WIDTH  data input selected when genericF=0.
- genericF  input  1  select flag.
- genericOutput  output  WIDTH  selected data.

Interface (already decided): one clock (clk); reset (rst) is synchronous and active-high.

Behaviour:
- Select function: sel = genericF ? genericValue1 : genericValue2. All WIDTH bits switch together; no bit-slicing, no extension, no arithmetic.
- OUTPUT_REG=0:
  - genericOutput = sel, purely combinational, zero latency.
  - Output follows any input or flag change within the same delta/time step.
  - clk and rst have no effect.
  - No internal state, so no reset value applies.
- OUTPUT_REG=1:
  - On each rising clk edge with rst=1, genericOutput <= RESET_VALUE.
  - On each rising clk edge with rst=0, genericOutput <= sel sampled at that edge.
  - Latency is exactly 1 cycle from input/flag change to output change.
  - Output holds between edges; input glitches between edges are invisible.
  - rst is sampled only at the clock edge. Asserting rst between edges does not change the output until the next edge.
  - Reset wins over data at the same edge.
  - Reset mid-stream: the output goes to RESET_VALUE at the first edge with rst=1. At the first edge after rst drops, it loads the current sel; no extra bubble cycle.
  - Power-up value before the first reset edge is undefined. Consumers must reset before use.
- Boundary cases:
  - genericValue1 == genericValue2: output equals that value regardless of genericF.
  - Flag and data changing in the same cycle: output reflects the new flag applied to the new data (combinational), or the values sampled at the edge (registered).
  - All-ones and all-zeros inputs pass unmodified at full WIDTH.
- No handshake, no enables, no state machine.

Test Plan:
1. OUTPUT_REG=0, genericF=1:
   - V1=0, V2=1 -> genericOutput=0.
   - Then V1=1, V2=0 -> genericOutput=1. Check 1 time unit after each change.
2. OUTPUT_REG=0, genericF=0:
   - V1=0, V2=1 -> genericOutput=1.
   - Then V1=1, V2=0 -> genericOutput=0.
3. OUTPUT_REG=0, width corners: V1=32'hFFFFFFFF, V2=32'h00000000, toggle genericF 1/0/1 -> output FFFFFFFF / 00000000 / FFFFFFFF with no clock applied.
4. OUTPUT_REG=1, RESET_VALUE=32'hDEADBEEF, rst=1 for 2 edges with V1=5, F=1:
   - genericOutput=DEADBEEF after the first edge.
   - Drop rst; next edge -> 5.
5. OUTPUT_REG=1, latency and hold:
   - F=1, V1=7, V2=9 → edge → 7.
   - Flip F=0 mid-cycle → output stays 7 until the next edge, then 9.
6. OUTPUT_REG=1, mid-operation reset:
   - Streaming V1=1,2,3 on successive edges with F=1.
   - Assert rst before the third edge → output RESET_VALUE at that edge.
   - Deassert rst → next edge loads the current V1.

Source files
------------

// File: rtl/mux_2to1.sv
// rtl/mux_2to1.sv - two-input word multiplexer with optional output register
module mux_2to1 #(
    parameter int               WIDTH       = 32,
    parameter bit               OUTPUT_REG  = 1'b0,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] genericValue1,
    input  logic [WIDTH-1:0] genericValue2,
    input  logic             genericF,
    output logic [WIDTH-1:0] genericOutput
);

    logic [WIDTH-1:0] sel;

    // Whole-word select; the flag picks genericValue1 when high.
    always_comb begin
        sel = genericF ? genericValue1 : genericValue2;
    end

    if (OUTPUT_REG) begin : gRegistered
        logic [WIDTH-1:0] outReg;

        // One-cycle output stage; reset takes priority over the sampled data.
        always_ff @(posedge clk) begin
            if (rst) begin
                outReg <= RESET_VALUE;
            end else begin
                outReg <= sel;
            end
        end

        assign genericOutput = outReg;
    end else begin : gCombinational
        // Clock and reset stay on the port list so both variants share one interface.
        logic unusedClkRst;
        assign unusedClkRst  = &{1'b0, clk, rst};
        assign genericOutput = sel;
    end

endmodule

// File: tb/tb_mux_2to1.sv
// tb/tb_mux_2to1.sv - directed self-checking bench for mux_2to1
module tb_mux_2to1;

    localparam int          WIDTH = 32;
    localparam logic [31:0] RVAL  = 32'hDEADBEEF;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] v1;
    logic [WIDTH-1:0] v2;
    logic             f;
    logic [WIDTH-1:0] outComb;
    logic [WIDTH-1:0] outReg;

    int checks = 0;
    int errors = 0;

    mux_2to1 #(.WIDTH(WIDTH), .OUTPUT_REG(1'b0), .RESET_VALUE(RVAL)) dutComb (
        .clk           (clk),
        .rst           (rst),
        .genericValue1 (v1),
        .genericValue2 (v2),
        .genericF      (f),
        .genericOutput (outComb)
    );

    mux_2to1 #(.WIDTH(WIDTH), .OUTPUT_REG(1'b1), .RESET_VALUE(RVAL)) dutReg (
        .clk           (clk),
        .rst           (rst),
        .genericValue1 (v1),
        .genericValue2 (v2),
        .genericF      (f),
        .genericOutput (outReg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_comb_flag_high;
        f = 1'b1; v1 = 32'd0; v2 = 32'd1; #1;
        checks++;
        if (outComb !== 32'd0) begin
            errors++; $display("FAIL comb_f1_a got %h exp %h", outComb, 32'd0);
        end
        v1 = 32'd1; v2 = 32'd0; #1;
        checks++;
        if (outComb !== 32'd1) begin
            errors++; $display("FAIL comb_f1_b got %h exp %h", outComb, 32'd1);
        end
    endtask

    task automatic test_comb_flag_low;
        f = 1'b0; v1 = 32'd0; v2 = 32'd1; #1;
        checks++;
        if (outComb !== 32'd1) begin
            errors++; $display("FAIL comb_f0_a got %h exp %h", outComb, 32'd1);
        end
        v1 = 32'd1; v2 = 32'd0; #1;
        checks++;
        if (outComb !== 32'd0) begin
            errors++; $display("FAIL comb_f0_b got %h exp %h", outComb, 32'd0);
        end
    endtask

    task automatic test_comb_corners;
        logic        fSeq [3];
        logic [31:0] expSeq [3];
        fSeq   = '{1'b1, 1'b0, 1'b1};
        expSeq = '{32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF};
        v1 = 32'hFFFFFFFF; v2 = 32'h00000000;
        for (int i = 0; i < 3; i++) begin
            f = fSeq[i]; #1;
            checks++;
            if (outComb !== expSeq[i]) begin
                errors++; $display("FAIL comb_corner_%0d got %h exp %h", i, outComb, expSeq[i]);
            end
        end
        v1 = 32'hA5A5_5A5A; v2 = 32'hA5A5_5A5A;
        for (int i = 0; i < 2; i++) begin
            f = i[0]; #1;
            checks++;
            if (outComb !== 32'hA5A5_5A5A) begin
                errors++; $display("FAIL comb_equal_%0d got %h exp %h", i, outComb, 32'hA5A5_5A5A);
            end
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst = 1'b1; v1 = 32'd5; v2 = 32'd0; f = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (outReg !== RVAL) begin
            errors++; $display("FAIL reset_edge1 got %h exp %h", outReg, RVAL);
        end
        @(posedge clk); #1;
        checks++;
        if (outReg !== RVAL) begin
            errors++; $display("FAIL reset_edge2 got %h exp %h", outReg, RVAL);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (outReg !== 32'd5) begin
            errors++; $display("FAIL reset_release got %h exp %h", outReg, 32'd5);
        end
    endtask

    task automatic test_latency_hold;
        @(negedge clk);
        f = 1'b1; v1 = 32'd7; v2 = 32'd9;
        @(posedge clk); #1;
        checks++;
        if (outReg !== 32'd7) begin
            errors++; $display("FAIL lat_load got %h exp %h", outReg, 32'd7);
        end
        @(negedge clk);
        f = 1'b0; #1;
        checks++;
        if (outReg !== 32'd7) begin
            errors++; $display("FAIL lat_hold got %h exp %h", outReg, 32'd7);
        end
        checks++;
        if (outComb !== 32'd9) begin
            errors++; $display("FAIL lat_comb_follow got %h exp %h", outComb, 32'd9);
        end
        v2 = 32'h1234; #1;
        v2 = 32'd9;
        @(posedge clk); #1;
        checks++;
        if (outReg !== 32'd9) begin
            errors++; $display("FAIL lat_switch got %h exp %h", outReg, 32'd9);
        end
    endtask

    task automatic test_mid_reset;
        @(negedge clk);
        f = 1'b1; v1 = 32'd1;
        @(posedge clk); #1;
        checks++;
        if (outReg !== 32'd1) begin
            errors++; $display("FAIL mid_s1 got %h exp %h", outReg, 32'd1);
        end
        @(negedge clk);
        v1 = 32'd2;
        @(posedge clk); #1;
        checks++;
        if (outReg !== 32'd2) begin
            errors++; $display("FAIL mid_s2 got %h exp %h", outReg, 32'd2);
        end
        @(negedge clk);
        v1 = 32'd3; rst = 1'b1; #1;
        checks++;
        if (outReg !== 32'd2) begin
            errors++; $display("FAIL mid_rst_between_edges got %h exp %h", outReg, 32'd2);
        end
        @(posedge clk); #1;
        checks++;
        if (outReg !== RVAL) begin
            errors++; $display("FAIL mid_rst_edge got %h exp %h", outReg, RVAL);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (outReg !== 32'd3) begin
            errors++; $display("FAIL mid_release got %h exp %h", outReg, 32'd3);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] a   [4];
        logic [31:0] b   [4];
        logic        fl  [4];
        logic [31:0] exp [4];
        a   = '{32'h0000_0011, 32'hFFFF_FFFF, 32'h0000_0033, 32'h8000_0001};
        b   = '{32'h0000_0022, 32'h0000_0000, 32'h0000_0044, 32'h7FFF_FFFE};
        fl  = '{1'b1, 1'b0, 1'b0, 1'b1};
        exp = '{32'h0000_0011, 32'h0000_0000, 32'h0000_0044, 32'h8000_0001};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            v1 = a[i]; v2 = b[i]; f = fl[i];
            @(posedge clk); #1;
            checks++;
            if (outReg !== exp[i]) begin
                errors++; $display("FAIL b2b_%0d got %h exp %h", i, outReg, exp[i]);
            end
        end
    endtask

    initial begin
        rst = 1'b0; v1 = '0; v2 = '0; f = 1'b0;
        test_comb_flag_high();
        test_comb_flag_low();
        test_comb_corners();
        test_reset();
        test_latency_hold();
        test_mid_reset();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
